// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the halt word and the absolute-jump target table.
package fetch_pkg;

    // Geometry of the jump table contents held in this package.
    localparam int FETCH_PCW  = 10;
    localparam int FETCH_LUTW = 4;
    localparam int LUT_DEPTH  = 2 ** FETCH_LUTW;

    // Instruction word that stops the program.
    localparam logic [8:0] HALT_WORD = 9'h1FF;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    // Absolute jump targets, indexed by the low bits of the Target field.
    localparam logic [FETCH_PCW-1:0] JUMP_LUT [LUT_DEPTH] = '{
        10'h000, 10'h010, 10'h0C4, 10'h123,
        10'h1F0, 10'h2A0, 10'h333, 10'h08A,
        10'h3FE, 10'h155, 10'h200, 10'h0FF,
        10'h2D7, 10'h3C0, 10'h111, 10'h040
    };

endpackage

// File: rtl/jump_lut.sv
// Combinational lookup of an absolute jump target from the shared table.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int PCW  = 10,
    parameter int LUTW = 4
) (
    input  logic [LUTW-1:0] idx_i,
    output logic [PCW-1:0]  target_o
);

    // Table read; index is widened to the table's native index width.
    always_comb begin
        target_o = PCW'(JUMP_LUT[FETCH_LUTW'(idx_i)]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, qualifies the current
// word for decode, and selects the next PC from the decoder's branch
// controls. Runs a Start/Done handshake and stops on the halt word.
// Optional feature macro: FETCH_STALL_EN adds a Stall input that freezes
// the PC and state while running.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PCW  = 10,
    parameter int IW   = 9,
    parameter int OFFW = 6,
    parameter int LUTW = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [IW-1:0]   Instr,
    input  logic            Branch,
    input  logic            absj,
    input  logic            Taken,
    input  logic [OFFW-1:0] Target,
`ifdef FETCH_STALL_EN
    input  logic            Stall,
`endif
    output logic [PCW-1:0]  ProgCtr,
    output logic            Valid,
    output logic            Done
);

    localparam logic [IW-1:0] HALT_I = IW'(HALT_WORD);

    fetch_state_t   state_q;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;
    logic           done_q;

    logic           stall_s;
    logic           halt_s;
    logic           valid_s;
    logic           take_s;
    logic [PCW-1:0] lut_pc_s;
    logic [PCW-1:0] rel_pc_s;
    logic [PCW-1:0] seq_pc_s;

`ifdef FETCH_STALL_EN
    assign stall_s = Stall;
`else
    assign stall_s = 1'b0;
`endif

    // Absolute-jump target for the current LUT index.
    jump_lut #(
        .PCW  (PCW),
        .LUTW (LUTW)
    ) u_jump_lut (
        .idx_i    (Target[LUTW-1:0]),
        .target_o (lut_pc_s)
    );

    // Decode qualification: halt detection, execute-valid and branch take.
    always_comb begin
        halt_s  = (Instr == HALT_I);
        valid_s = (state_q == ST_RUN) && !halt_s && !stall_s;
        take_s  = valid_s && Branch && Taken;
    end

    // Next-PC selection; all additions wrap modulo 2^PCW.
    always_comb begin
        seq_pc_s = pc_q + PCW'(1'b1);
        rel_pc_s = pc_q + PCW'($signed(Target));
        if (take_s) begin
            if (absj) begin
                pc_d = lut_pc_s;
            end else begin
                pc_d = rel_pc_s;
            end
        end else begin
            pc_d = seq_pc_s;
        end
    end

    // Fetch FSM with registered PC and Done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= {PCW{1'b0}};
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_q <= ST_RUN;
                        pc_q    <= {PCW{1'b0}};
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stall_s) begin
                        state_q <= ST_RUN;
                    end else if (halt_s) begin
                        // PC stays on the halt word.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= pc_d;
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        state_q <= ST_RUN;
                        pc_q    <= {PCW{1'b0}};
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pc_q    <= {PCW{1'b0}};
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr = pc_q;
    assign Valid   = valid_s;
    assign Done    = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// programs, all checked cycle by cycle against a behavioural model.
module tb_fetch_unit;

    localparam int DEPTH = 1024;
    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_STALL_EN
    localparam bit HAS_STALL = 1'b1;
`else
    localparam bit HAS_STALL = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [8:0] Instr;
    logic       Branch;
    logic       absj;
    logic       Taken;
    logic [5:0] Target;
`ifdef FETCH_STALL_EN
    logic       Stall;
`endif
    logic [9:0] ProgCtr;
    logic       Valid;
    logic       Done;

    // Program ROM and the per-address decoder outputs.
    logic [8:0] rom  [DEPTH];
    logic       br_t [DEPTH];
    logic       ab_t [DEPTH];
    logic       tk_t [DEPTH];
    logic [5:0] tg_t [DEPTH];
    logic [9:0] ref_lut [16];

    int n_cmp = 0;
    int n_mis = 0;
    int m_mode;   // 0 idle, 1 running, 2 halted
    int m_pc;
    int valid_cnt;

    assign Instr  = rom[ProgCtr];
    assign Branch = br_t[ProgCtr];
    assign absj   = ab_t[ProgCtr];
    assign Taken  = tk_t[ProgCtr];
    assign Target = tg_t[ProgCtr];

    always #5 Clk = ~Clk;

    fetch_unit #(.PCW(10), .IW(9), .OFFW(6), .LUTW(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Instr   (Instr),
        .Branch  (Branch),
        .absj    (absj),
        .Taken   (Taken),
        .Target  (Target),
`ifdef FETCH_STALL_EN
        .Stall   (Stall),
`endif
        .ProgCtr (ProgCtr),
        .Valid   (Valid),
        .Done    (Done)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic int exp_valid(input logic sl);
        return ((m_mode == 1) && (rom[m_pc] != HALT) && !(HAS_STALL && sl)) ? 1 : 0;
    endfunction

    // Reference behaviour for one rising edge.
    task automatic model_edge(input logic st, input logic sl);
        int off;
        case (m_mode)
            0, 2: begin
                if (st) begin
                    m_mode = 1;
                    m_pc   = 0;
                end
            end
            1: begin
                if (!(HAS_STALL && sl)) begin
                    if (rom[m_pc] == HALT) begin
                        m_mode = 2;
                    end else if (br_t[m_pc] && tk_t[m_pc]) begin
                        if (ab_t[m_pc]) begin
                            m_pc = int'(ref_lut[int'(tg_t[m_pc]) % 16]);
                        end else begin
                            off = int'(tg_t[m_pc]);
                            if (off >= 32) off = off - 64;
                            m_pc = (m_pc + off + DEPTH) % DEPTH;
                        end
                    end else begin
                        m_pc = (m_pc + 1) % DEPTH;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock cycle: drive, check mid-cycle, advance model past the edge.
    task automatic cycle(input logic st, input logic sl);
        Start = st;
`ifdef FETCH_STALL_EN
        Stall = sl;
`endif
        @(negedge Clk);
        check_eq("pc", int'(ProgCtr), m_pc);
        check_eq("valid", int'(Valid), exp_valid(sl));
        check_eq("done", int'(Done), (m_mode == 2) ? 1 : 0);
        if (Valid) valid_cnt++;
        @(posedge Clk);
        model_edge(st, sl);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) begin
            rom[i]  = 9'($urandom_range(510, 0));
            br_t[i] = 1'b0;
            ab_t[i] = 1'b0;
            tk_t[i] = 1'b0;
            tg_t[i] = 6'($urandom_range(63, 0));
        end
    endtask

    task automatic random_prog();
        for (int i = 0; i < DEPTH; i++) begin
            rom[i]  = ($urandom_range(23, 0) == 0) ? HALT : 9'($urandom_range(510, 0));
            br_t[i] = ($urandom_range(3, 0) == 0);
            ab_t[i] = 1'($urandom_range(1, 0));
            tk_t[i] = 1'($urandom_range(1, 0));
            tg_t[i] = 6'($urandom_range(63, 0));
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        Start = 1'b0;
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check_eq("rst_pc", int'(ProgCtr), 0);
        check_eq("rst_valid", int'(Valid), 0);
        check_eq("rst_done", int'(Done), 0);
        m_mode = 0;
        m_pc   = 0;
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        ref_lut = '{10'h000, 10'h010, 10'h0C4, 10'h123,
                    10'h1F0, 10'h2A0, 10'h333, 10'h08A,
                    10'h3FE, 10'h155, 10'h200, 10'h0FF,
                    10'h2D7, 10'h3C0, 10'h111, 10'h040};
        clear_prog();
        Reset_n = 1'b0;
        Start   = 1'b0;
`ifdef FETCH_STALL_EN
        Stall   = 1'b0;
`endif
        m_mode = 0;
        m_pc   = 0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("reset_pc", int'(ProgCtr), 0);
        check_eq("reset_valid", int'(Valid), 0);
        check_eq("reset_done", int'(Done), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Straight-line program ending in a halt at address 4.
        clear_prog();
        rom[4] = HALT;
        valid_cnt = 0;
        cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b0);
        check_eq("a_valid_cnt", valid_cnt, 4);
        check_eq("a_done", int'(Done), 1);
        check_eq("a_pc_hold", int'(ProgCtr), 4);

        // Relative branch at 5 (-2), then absolute branch at 8 via LUT[5].
        clear_prog();
        br_t[5] = 1'b1; tk_t[5] = 1'b1; tg_t[5] = 6'h3E;
        br_t[8] = 1'b1; ab_t[8] = 1'b1; tk_t[8] = 1'b1; tg_t[8] = 6'h25;
        rom[10'h2A0] = HALT;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        check_eq("rel_taken", int'(ProgCtr), 3);
        tk_t[5] = 1'b0;
        repeat (2) cycle(1'b0, 1'b0);
        check_eq("rel_at5", int'(ProgCtr), 5);
        cycle(1'b0, 1'b0);
        check_eq("rel_not_taken", int'(ProgCtr), 6);
        repeat (3) cycle(1'b0, 1'b0);
        check_eq("abs_jump", int'(ProgCtr), 10'h2A0);
        cycle(1'b0, 1'b0);
        check_eq("abs_done", int'(Done), 1);

        // Wrap at the top of the address space, sequential then relative +2.
        clear_prog();
        br_t[0] = 1'b1; ab_t[0] = 1'b1; tk_t[0] = 1'b1; tg_t[0] = 6'd8;
        br_t[10'h3FF] = 1'b1; tg_t[10'h3FF] = 6'd2;
        rom[1] = HALT;
        cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        check_eq("wrap_top", int'(ProgCtr), 10'h3FF);
        cycle(1'b0, 1'b0);
        check_eq("wrap_seq", int'(ProgCtr), 0);
        cycle(1'b0, 1'b0);
        tk_t[10'h3FF] = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check_eq("wrap_rel", int'(ProgCtr), 1);
        cycle(1'b0, 1'b0);
        check_eq("wrap_done", int'(Done), 1);

        // Start held high while running is ignored; reset hits at PC 7.
        clear_prog();
        cycle(1'b1, 1'b0);
        repeat (7) cycle(1'b1, 1'b0);
        check_eq("start_ignored_pc", int'(ProgCtr), 7);
        mid_reset();
        repeat (2) cycle(1'b0, 1'b0);
        check_eq("idle_after_rst", int'(ProgCtr), 0);

`ifdef FETCH_STALL_EN
        // Stall over a taken branch at PC 2; branch resolves on release.
        clear_prog();
        br_t[2] = 1'b1; tk_t[2] = 1'b1; tg_t[2] = 6'd5;
        rom[7] = HALT;
        cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        check_eq("stall_pc", int'(ProgCtr), 2);
        cycle(1'b0, 1'b0);
        check_eq("stall_release", int'(ProgCtr), 7);
        cycle(1'b0, 1'b0);
`endif

        // Randomized programs, start pulses and stalls.
        for (int r = 0; r < 4; r++) begin
            random_prog();
            for (int c = 0; c < 250; c++) begin
                cycle(($urandom_range(9, 0) == 0),
                      (HAS_STALL && ($urandom_range(3, 0) == 0)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that feeds the control decoder: owns the program counter, presents the current machine word to decode, and resolves the next PC from the decoder's `Branch`/`absj` outputs and the ALU condition flag. It runs a Start/Done handshake with the top-level testbench and stops on a halt word. Single-cycle datapath; the PC updates on every rising edge while running.

## Interface
Parameters:
- `PCW`, 10: program counter width; instruction memory depth is 2^PCW
- `IW`, 9: instruction width
- `OFFW`, 6: width of the `Target` field
- `LUTW`, 4: absolute-jump LUT index width; must be ≤ OFFW

Ports:
- `Clk` in 1: clock, rising edge
- `Reset_n` in 1: asynchronous, active-low reset
- `Start` in 1: level, begin or restart the program at PC 0
- `Instr` in IW: word from instruction ROM, combinational read of `ProgCtr`
- `Branch` in 1: from the control decoder; the current instruction is a branch
- `absj` in 1: from the control decoder; the branch is absolute (LUT) rather than relative
- `Taken` in 1: ALU condition result for the current branch
- `Target` in OFFW: signed relative offset, or LUT index in bits [LUTW-1:0]
- `ProgCtr` out PCW: current PC, drives the ROM address
- `Valid` out 1: `Instr` is to be executed this cycle
- `Done` out 1: program halted

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `Start`=1.
  - RUN→DONE when `Instr`==HALT_WORD.
  - DONE→RUN when `Start`=1.
  - There are no other transitions. `Start` is ignored in RUN.
- Entering RUN, from IDLE or DONE, loads `ProgCtr`=0.
- `Valid` = (state==RUN) && (`Instr`≠HALT_WORD). This is combinational.
- `take` = `Valid` & `Branch` & `Taken`. A branch is ignored when `Valid`=0.
- Next PC in RUN:
  - `take` & `absj`: LUT[`Target`[LUTW-1:0]]. Upper `Target` bits are ignored.
  - `take` & !`absj`: `ProgCtr` + sign-extended `Target`, modulo 2^PCW.
  - Otherwise: `ProgCtr` + 1, modulo 2^PCW. The PC wraps from 2^PCW-1 to 0.
- On the halt word, `ProgCtr` holds its value and state moves to DONE.
- In IDLE and DONE, `ProgCtr` holds.
- `Done` is a registered output, equal to 1 exactly while state==DONE.
- A relative offset of 0 on a taken branch is a legal self-loop. The PC holds until the branch is not taken.

## Timing
- Reset values: state IDLE, `ProgCtr`=0, `Done`=0, `Valid`=0.
- Reset asserted mid-run forces these values immediately, without waiting for a clock edge.
- Start latency: `Start` is sampled at edge N. `Valid` can be 1 from edge N to N+1, with `ProgCtr`=0.
- Branch resolution has zero bubbles. The target PC is presented the cycle after the branch.
- Halt: the halt word is present in cycle K. `Done`=1 from edge K+1 onward.
- Restart with `Start` in DONE: `Done` falls at the next edge and `ProgCtr`=0.
- `Start` held high continuously starts the program once. In DONE it restarts again each halt, so the bench must pulse it.

## Configuration
- `FETCH_STALL_EN` defined:
  - Adds input `Stall` (1 bit).
  - While `Stall`=1 in RUN, `ProgCtr` and the state hold.
  - `Valid`=0, so branches and halt detection are suppressed.
  - `Stall` has no effect in IDLE or DONE.
- `FETCH_STALL_EN` undefined: no `Stall` port. Behaviour is as if `Stall`=0.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t`
  - `HALT_WORD` (9'h1FF)
  - `JUMP_LUT` constant array of 2^LUTW PC values
- Sub-module `jump_lut`: combinational, LUTW-bit index in, PCW-bit target out, contents from `JUMP_LUT`.
- The FSM, PC register and next-PC mux live in `fetch_unit`.

## Test plan
- Reset, then pulse `Start`, with ROM holding non-branches at 0..3 and HALT_WORD at 4. Required:
  - `ProgCtr` steps 0,1,2,3,4.
  - `Valid`=1 for 4 cycles.
  - `Done`=1 the cycle after PC 4.
- Relative branch at PC 5 with `Target`=6'h3E (−2) and `Taken`=1: next `ProgCtr`=3. With `Taken`=0: next `ProgCtr`=6.
- Absolute branch at PC 8 with `absj`=1, `Target`=6'h25, and `JUMP_LUT`[5]=10'h2A0: next `ProgCtr`=10'h2A0, so upper `Target` bits are ignored.
- Wrap: PC 10'h3FF with a non-branch goes to 0. A relative branch of +2 at 10'h3FF goes to 1.
- `Reset_n` low mid-run at PC 7: `ProgCtr`=0, `Done`=0, `Valid`=0 before the next edge. `Start` while in RUN is ignored.
- `FETCH_STALL_EN` build: `Stall`=1 for 3 cycles at PC 2, which holds a taken branch. PC stays 2 and `Valid`=0 throughout. When `Stall` releases, the branch is taken.
